prime_uart_tx: RTL and testbench
================================

// Module: prime_uart_tx
// PURPOSE
//  Downstream consumer for primogen results on icestick. Accepts one unsigned
//  W-bit value per handshake, converts it to decimal ASCII with leading zeros
//  suppressed, and sends it on a UART TX line (8N1, LSB first) followed by
//  CR LF. Sits between the prime-fetch loop (on its prime/go side) and the
//  FTDI serial pin.
// PARAMETERS
//  WIDTH_LOG     4    value width W = 1 << WIDTH_LOG (same meaning as in primogen)
//  CLKS_PER_BIT  104  clocks per UART bit (12 MHz / 115200); must be >= 2
//  (local) DIGITS = ((W*1233) >> 12) + 1 : max decimal digits (W=16 -> 5, W=32 -> 10)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous reset, active high
//  val        in   W  unsigned value to print
//  val_valid  in   1  val is presented
//  val_ready  out  1  block idle, will accept val this cycle
//  busy       out  1  conversion or transmission in progress
//  tx         out  1  UART serial output, idle high
// BEHAVIOUR
//  Reset: tx=1, busy=0, val_ready=0; val_ready rises on first clock after rst low.
//  Handshake: transfer on posedge with val_valid && val_ready. val is registered
//   on that edge; val_ready=0 and busy=1 from the next cycle. val and val_valid
//   are ignored while busy.
//  States: IDLE -> CONV -> LOAD -> TX -> (LOAD | IDLE).
//   IDLE: val_ready=1, tx=1. Accept -> CONV.
//   CONV: double-dabble, one shift per cycle, exactly W cycles. Leaves a
//    DIGITS x 4-bit BCD vector and the index of the most significant nonzero
//    digit. Value 0 gives one digit, "0".
//   LOAD: 1 cycle. Load a 10-bit frame {1, byte, 0}. Byte order: digits MSB
//    first as 0x30+d, then 0x0D, then 0x0A.
//   TX: shift the frame LSB first, each bit held exactly CLKS_PER_BIT cycles.
//    After the stop bit: -> LOAD if bytes remain, else -> IDLE.
//  Latency: tx first falls W+2 cycles after the accept edge.
//  Inter-byte gap = 1 LOAD cycle (tx held high, extends the stop bit by one clock).
//  Total busy time for N digits:
//   W + (N+2)*(10*CLKS_PER_BIT + 1) cycles.
//  busy falls, and val_ready rises, the cycle after the final stop bit.
//   Back-to-back accept is then possible.
//  Counters: bit counter 0..9, baud counter 0..CLKS_PER_BIT-1, byte index
//   0..DIGITS+1. All reload exactly, with no drift across bytes.
//  Reset mid-operation: abort immediately. tx=1 from the next cycle, even
//   mid-frame (a truncated frame is acceptable). All state returns to IDLE.
//  No overflow or error cases: every W-bit value fits in DIGITS digits.
// TESTING (sim with CLKS_PER_BIT=4, WIDTH_LOG=4; bench UART decoder samples mid-bit)
//  1. val=0 -> bytes 0x30,0x0D,0x0A; busy high 16+3*41 = 139 cycles.
//  2. val=7 -> 0x37,0x0D,0x0A; no leading '0' bytes; tx falls exactly 18
//     cycles after accept.
//  3. val=65521 -> "65521\r\n" (0x36,0x35,0x35,0x32,0x31,0x0D,0x0A);
//     each bit exactly 4 cycles, stop bits high.
//  4. val=65535 then val=10000 -> "65535\r\n10000\r\n"; inner zeros kept,
//     no digit dropped.
//  5. val_valid held high, val changing every cycle while busy -> only
//     values present on accept edges are sent; val_ready stays 0 throughout busy.
//  6. rst pulsed during 2nd bit of 3rd byte -> tx=1 next cycle, busy=0,
//     val_ready=0 during rst and 1 one cycle after release; then val=13
//     -> clean "13\r\n".

Source files
------------

// File: rtl/prime_uart_tx.sv
// Prints one unsigned value per handshake as decimal ASCII (leading zeros suppressed)
// followed by CR LF on an 8N1 UART line.
//
// state | meaning
// IDLE  | ready for a value, line idle high
// CONV  | double-dabble binary to BCD, one shift per clock
// LOAD  | build the next 10-bit frame {stop, byte, start}
// TX    | shift the frame out LSB first, CLKS_PER_BIT clocks per bit
module prime_uart_tx #(
   parameter int WIDTH_LOG    = 4,
   parameter int CLKS_PER_BIT = 104
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [(1<<WIDTH_LOG)-1:0]   val,
   input  logic                        val_valid,
   output logic                        val_ready,
   output logic                        busy,
   output logic                        tx
);
   localparam int W      = 1 << WIDTH_LOG;
   localparam int DIGITS = ((W * 1233) >> 12) + 1;
   localparam int BW     = DIGITS * 4;
   localparam int BIW    = $clog2(DIGITS + 2);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CONV = 2'd1;
   localparam logic [1:0] LOAD = 2'd2;
   localparam logic [1:0] TX   = 2'd3;

   logic [1:0]           state;
   logic [W-1:0]         bin;
   logic [BW-1:0]        bcd;
   logic [BW-1:0]        bcd_adj;
   logic [BW-1:0]        bcd_next;
   logic [WIDTH_LOG-1:0] conv_cnt;
   logic [BIW-1:0]       byte_idx;
   logic [BIW-1:0]       msd;
   logic [BIW-1:0]       start_idx;
   logic [BIW-1:0]       dsel;
   logic [3:0]           cur_digit;
   logic [7:0]           cur_byte;
   logic [9:0]           frame;
   logic [3:0]           bit_cnt;
   logic [BAUD_W-1:0]    baud_cnt;
   logic                 tx_q;
   logic                 rdy;

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5)
            bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
      bcd_next = {bcd_adj[BW-2:0], bin[W-1]};
   end

   // Byte positions 0..DIGITS-1 are digits MSB first; leading zeros are skipped
   // by starting the index at the most significant nonzero digit.
   always_comb begin
      msd = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_next[i*4 +: 4] != 4'd0)
            msd = BIW'(i);
      end
      start_idx = BIW'(DIGITS - 1) - msd;
   end

   always_comb begin
      dsel      = BIW'(DIGITS - 1) - byte_idx;
      cur_digit = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (dsel == BIW'(i))
            cur_digit = bcd[i*4 +: 4];
      end
      if (byte_idx == BIW'(DIGITS))
         cur_byte = 8'h0D;
      else if (byte_idx == BIW'(DIGITS + 1))
         cur_byte = 8'h0A;
      else
         cur_byte = {4'h3, cur_digit};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rdy      <= 1'b0;
         tx_q     <= 1'b1;
         bin      <= '0;
         bcd      <= '0;
         conv_cnt <= '0;
         byte_idx <= '0;
         frame    <= '1;
         bit_cnt  <= '0;
         baud_cnt <= '0;
      end else begin
         tx_q <= (state == TX) ? frame[0] : 1'b1;
         case (state)
            IDLE: begin
               rdy <= 1'b1;
               if (val_valid && rdy) begin
                  bin      <= val;
                  bcd      <= '0;
                  conv_cnt <= WIDTH_LOG'(W - 1);
                  rdy      <= 1'b0;
                  state    <= CONV;
               end
            end
            CONV: begin
               bcd <= bcd_next;
               bin <= {bin[W-2:0], 1'b0};
               if (conv_cnt == '0) begin
                  byte_idx <= start_idx;
                  state    <= LOAD;
               end else begin
                  conv_cnt <= conv_cnt - 1'b1;
               end
            end
            LOAD: begin
               frame    <= {1'b1, cur_byte, 1'b0};
               bit_cnt  <= 4'd0;
               baud_cnt <= BAUD_W'(CLKS_PER_BIT - 1);
               state    <= TX;
            end
            TX: begin
               if (baud_cnt == '0) begin
                  baud_cnt <= BAUD_W'(CLKS_PER_BIT - 1);
                  frame    <= {1'b1, frame[9:1]};
                  if (bit_cnt == 4'd9) begin
                     if (byte_idx == BIW'(DIGITS + 1)) begin
                        rdy   <= 1'b1;
                        state <= IDLE;
                     end else begin
                        byte_idx <= byte_idx + 1'b1;
                        state    <= LOAD;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign val_ready = rdy;
   assign busy      = (state != IDLE);
   assign tx        = tx_q;
endmodule

// File: tb/tb_prime_uart_tx.sv
// Bench for prime_uart_tx: mid-bit UART decoder feeding a byte scoreboard.
module tb_prime_uart_tx;
   localparam int WL  = 4;
   localparam int CPB = 4;
   localparam int W   = 1 << WL;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] val = '0;
   logic         val_valid = 1'b0;
   logic         val_ready;
   logic         busy;
   logic         tx;

   int errors = 0;
   int checks = 0;

   // Entries are {bit-timing error, stop bit, data}; a clean byte is {0, 1, data}.
   logic [9:0] exp_q[$];
   logic [9:0] rx_q[$];

   prime_uart_tx #(.WIDTH_LOG(WL), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst), .val(val), .val_valid(val_valid),
      .val_ready(val_ready), .busy(busy), .tx(tx)
   );

   always #5 clk = ~clk;

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : decoder
      logic       smp [0:39];
      int         pos;
      bit         active;
      logic [7:0] d;
      logic       jit;
      active = 0;
      pos = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            active = 0;
         end else if (!active) begin
            if (tx === 1'b0) begin
               active = 1;
               smp[0] = tx;
               pos = 1;
            end
         end else begin
            smp[pos] = tx;
            pos++;
            if (pos == 40) begin
               active = 0;
               jit = 1'b0;
               for (int b = 0; b < 10; b++)
                  for (int k = 0; k < CPB; k++)
                     if (smp[b*CPB+k] !== smp[b*CPB+2]) jit = 1'b1;
               if (smp[2] !== 1'b0) jit = 1'b1;
               for (int b = 0; b < 8; b++) d[b] = smp[(b+1)*CPB+2];
               rx_q.push_back({jit, smp[38], d});
            end
         end
      end
   end

   task automatic push_exp(input int v);
      int dg[$];
      int x;
      x = v;
      if (x == 0) dg.push_front(0);
      while (x > 0) begin
         dg.push_front(x % 10);
         x = x / 10;
      end
      foreach (dg[i]) exp_q.push_back({2'b01, 8'(8'h30 + dg[i])});
      exp_q.push_back({2'b01, 8'h0D});
      exp_q.push_back({2'b01, 8'h0A});
   endtask

   task automatic send_val(input int v);
      int n;
      n = 0;
      @(negedge clk);
      while (val_ready !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (val_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_timeout: val_ready=%b required 1", val_ready);
      end
      val = W'(v);
      val_valid = 1'b1;
      @(posedge clk);
      #1 val_valid = 1'b0;
   endtask

   task automatic wait_rx(input int n);
      int c;
      c = 0;
      while (rx_q.size() < n && c < 5000) begin
         @(negedge clk);
         c++;
      end
      repeat (2) @(negedge clk);
      if (rx_q.size() < n) begin
         errors++;
         $display("FAIL rx_timeout: got %0d bytes required %0d", rx_q.size(), n);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b required 1", tx); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
      checks++;
      if (val_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", val_ready); end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (val_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b required 1", val_ready); end
   endtask

   task automatic test_zero;
      int cnt;
      logic [9:0] e, r;
      rx_q.delete();
      push_exp(0);
      send_val(0);
      cnt = 0;
      forever begin
         @(negedge clk);
         if (busy !== 1'b1 || cnt > 1000) break;
         cnt++;
      end
      checks++;
      if (cnt !== W + 3 * (10 * CPB + 1)) begin
         errors++; $display("FAIL zero_busy_cycles: got %0d required %0d", cnt, W + 3 * (10 * CPB + 1));
      end
      wait_rx(exp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         r = (rx_q.size() > 0) ? rx_q.pop_front() : 10'h3FF;
         checks++;
         if (r !== e) begin errors++; $display("FAIL zero_byte: got %h required %h", r, e); end
      end
   endtask

   task automatic test_latency;
      int j;
      logic [9:0] e, r;
      rx_q.delete();
      push_exp(7);
      send_val(7);
      j = 0;
      while (j < 100) begin
         @(posedge clk);
         j++;
         @(negedge clk);
         if (tx === 1'b0) break;
      end
      checks++;
      if (j !== W + 2) begin errors++; $display("FAIL latency_tx_fall: got %0d required %0d", j, W + 2); end
      wait_rx(exp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         r = (rx_q.size() > 0) ? rx_q.pop_front() : 10'h3FF;
         checks++;
         if (r !== e) begin errors++; $display("FAIL latency_byte: got %h required %h", r, e); end
      end
   endtask

   task automatic test_five_digits;
      logic [9:0] e, r;
      rx_q.delete();
      push_exp(65521);
      send_val(65521);
      wait_rx(exp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         r = (rx_q.size() > 0) ? rx_q.pop_front() : 10'h3FF;
         checks++;
         if (r !== e) begin errors++; $display("FAIL five_digit_byte: got %h required %h", r, e); end
      end
   endtask

   task automatic test_back_to_back;
      logic [9:0] e, r;
      rx_q.delete();
      push_exp(65535);
      push_exp(10000);
      send_val(65535);
      send_val(10000);
      wait_rx(exp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         r = (rx_q.size() > 0) ? rx_q.pop_front() : 10'h3FF;
         checks++;
         if (r !== e) begin errors++; $display("FAIL back_to_back_byte: got %h required %h", r, e); end
      end
   endtask

   task automatic test_ignore_while_busy;
      int accepts, viol, n;
      int v;
      logic [9:0] e, r;
      rx_q.delete();
      accepts = 0;
      viol = 0;
      n = 0;
      while (accepts < 3 && n < 4000) begin
         @(negedge clk);
         n++;
         v = int'($urandom_range(0, 65535));
         val = W'(v);
         val_valid = 1'b1;
         if (busy === 1'b1 && val_ready !== 1'b0) viol++;
         if (val_ready === 1'b1) begin
            push_exp(v);
            accepts++;
         end
      end
      @(posedge clk);
      #1 val_valid = 1'b0;
      checks++;
      if (viol !== 0 || accepts !== 3) begin
         errors++; $display("FAIL busy_ready: violations %0d accepts %0d required 0 and 3", viol, accepts);
      end
      wait_rx(exp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         r = (rx_q.size() > 0) ? rx_q.pop_front() : 10'h3FF;
         checks++;
         if (r !== e) begin errors++; $display("FAIL ignore_busy_byte: got %h required %h", r, e); end
      end
   endtask

   task automatic test_mid_reset;
      int n;
      logic [9:0] e, r;
      rx_q.delete();
      exp_q.push_back({2'b01, 8'h31});
      exp_q.push_back({2'b01, 8'h32});
      send_val(123);
      wait_rx(2);
      n = 0;
      forever begin
         @(negedge clk);
         n++;
         if (tx === 1'b0 || n > 200) break;
      end
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b required 1", tx); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", busy); end
      checks++;
      if (val_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b required 0", val_ready); end
      @(negedge clk);
      checks++;
      if (val_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready_held: got %b required 0", val_ready); end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (val_ready !== 1'b1) begin errors++; $display("FAIL midrst_release_ready: got %b required 1", val_ready); end
      checks++;
      if (rx_q.size() !== 2) begin errors++; $display("FAIL midrst_rx_count: got %0d required 2", rx_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         r = (rx_q.size() > 0) ? rx_q.pop_front() : 10'h3FF;
         checks++;
         if (r !== e) begin errors++; $display("FAIL midrst_byte: got %h required %h", r, e); end
      end
      rx_q.delete();
      push_exp(13);
      send_val(13);
      wait_rx(exp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         r = (rx_q.size() > 0) ? rx_q.pop_front() : 10'h3FF;
         checks++;
         if (r !== e) begin errors++; $display("FAIL after_rst_byte: got %h required %h", r, e); end
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_latency();
      test_five_digits();
      test_back_to_back();
      test_ignore_while_busy();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
